// File: rtl/multiport_load_queue.sv
// Multi-lane circular load queue: group allocation, AGU address writeback,
// sleep/wakeup, store forwarding, in-order retire and pipeline flush.
module multiport_load_queue #(
  parameter int XLEN          = 32,
  parameter int ROB_TAG_WIDTH = 32,
  parameter int LDQ_SIZE      = 8,
  parameter int STQ_SIZE      = 8,
  parameter int ALLOC_PORTS   = 2,
  parameter int AGU_PORTS     = 2
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic [ALLOC_PORTS-1:0]                         alloc_valid,
  input  logic [ALLOC_PORTS-1:0][ROB_TAG_WIDTH-1:0]      alloc_rob_tag,
  input  logic [ALLOC_PORTS-1:0][STQ_SIZE-1:0]           alloc_store_mask,
  output logic                                           alloc_ready,
  output logic [ALLOC_PORTS-1:0][$clog2(LDQ_SIZE)-1:0]   alloc_index,
  input  logic [AGU_PORTS-1:0]                           agu_valid,
  input  logic [AGU_PORTS-1:0][XLEN-1:0]                 agu_address,
  input  logic [AGU_PORTS-1:0][ROB_TAG_WIDTH-1:0]        agu_rob_tag,
  input  logic                                           cdb_active,
  input  logic [ROB_TAG_WIDTH-1:0]                       cdb_tag,
  input  logic                                           load_fired,
  input  logic [$clog2(LDQ_SIZE)-1:0]                    load_fired_index,
  input  logic                                           load_fired_sleep,
  input  logic [ROB_TAG_WIDTH-1:0]                       load_fired_sleep_rob_tag,
  input  logic                                           load_fired_forward,
  input  logic [$clog2(STQ_SIZE)-1:0]                    load_fired_forward_index,
  input  logic                                           load_succeeded,
  input  logic [ROB_TAG_WIDTH-1:0]                       load_succeeded_rob_tag,
  input  logic                                           rob_commit,
  input  logic [ROB_TAG_WIDTH-1:0]                       rob_commit_tag,
  input  logic [LDQ_SIZE-1:0]                            order_failures,
  input  logic                                           store_fired,
  input  logic [$clog2(STQ_SIZE)-1:0]                    store_fired_index,
  input  logic                                           flush,
  output logic [LDQ_SIZE-1:0]                            ldq_valid,
  output logic [LDQ_SIZE-1:0][XLEN-1:0]                  ldq_address,
  output logic [LDQ_SIZE-1:0]                            ldq_address_valid,
  output logic [LDQ_SIZE-1:0]                            ldq_sleeping,
  output logic [LDQ_SIZE-1:0][ROB_TAG_WIDTH-1:0]         ldq_sleep_rob_tag,
  output logic [LDQ_SIZE-1:0]                            ldq_executed,
  output logic [LDQ_SIZE-1:0]                            ldq_succeeded,
  output logic [LDQ_SIZE-1:0]                            ldq_committed,
  output logic [LDQ_SIZE-1:0]                            ldq_order_fail,
  output logic [LDQ_SIZE-1:0][STQ_SIZE-1:0]              ldq_store_mask,
  output logic [LDQ_SIZE-1:0]                            ldq_forwarded,
  output logic [LDQ_SIZE-1:0][$clog2(STQ_SIZE)-1:0]      ldq_forward_stq_index,
  output logic [LDQ_SIZE-1:0][ROB_TAG_WIDTH-1:0]         ldq_rob_tag,
  output logic [LDQ_SIZE-1:0]                            ldq_rotated_valid,
  output logic [LDQ_SIZE-1:0]                            ldq_rotated_address_valid,
  output logic [LDQ_SIZE-1:0]                            ldq_rotated_sleeping,
  output logic [LDQ_SIZE-1:0]                            ldq_rotated_executed,
  output logic [$clog2(LDQ_SIZE)-1:0]                    head,
  output logic [$clog2(LDQ_SIZE)-1:0]                    tail,
  output logic [$clog2(LDQ_SIZE):0]                      count,
  output logic                                           full,
  output logic                                           empty
);

  localparam int IW = $clog2(LDQ_SIZE);
  localparam int SW = $clog2(STQ_SIZE);
  localparam int CW = IW + 1;

  typedef struct packed {
    logic                     valid;
    logic [XLEN-1:0]          address;
    logic                     address_valid;
    logic                     sleeping;
    logic [ROB_TAG_WIDTH-1:0] sleep_rob_tag;
    logic                     executed;
    logic                     succeeded;
    logic                     committed;
    logic                     order_fail;
    logic [STQ_SIZE-1:0]      store_mask;
    logic                     forwarded;
    logic [SW-1:0]            forward_stq_index;
    logic [ROB_TAG_WIDTH-1:0] rob_tag;
  } entry_t;

  entry_t [LDQ_SIZE-1:0] ent;
  entry_t [LDQ_SIZE-1:0] ent_nxt;

  logic          retire;
  logic          do_alloc;
  logic [IW-1:0] lane_offset;
  logic [CW-1:0] n_alloc;
  logic [CW-1:0] n_commit;
  logic [IW-1:0] head_nxt;
  logic [IW-1:0] tail_nxt;
  logic [CW-1:0] count_nxt;

  assign retire      = ent[head].committed;
  assign alloc_ready = (count <= CW'(LDQ_SIZE - ALLOC_PORTS));
  assign full        = (count == CW'(LDQ_SIZE));
  assign empty       = (count == '0);
  assign do_alloc    = alloc_ready && !flush && (|alloc_valid);

  // Lane k lands at tail plus the number of requesting lanes below it.
  always_comb begin
    lane_offset = '0;
    for (int k = 0; k < ALLOC_PORTS; k++) begin
      alloc_index[k] = tail + lane_offset;
      if (alloc_valid[k]) lane_offset = lane_offset + IW'(1);
    end
    n_alloc = {1'b0, lane_offset};
    n_commit = '0;
    for (int i = 0; i < LDQ_SIZE; i++) begin
      if (ent[i].valid && ent[i].committed) n_commit = n_commit + CW'(1);
    end
  end

  always_comb begin
    ent_nxt = ent;
    for (int i = 0; i < LDQ_SIZE; i++) begin
      if (ent[i].valid) begin
        for (int l = 0; l < AGU_PORTS; l++) begin
          if (agu_valid[l] && (agu_rob_tag[l] == ent[i].rob_tag)) begin
            ent_nxt[i].address       = agu_address[l];
            ent_nxt[i].address_valid = 1'b1;
          end
        end
        if (ent[i].sleeping && cdb_active && (cdb_tag == ent[i].sleep_rob_tag))
          ent_nxt[i].sleeping = 1'b0;
        // Applied after wakeup so a fresh sleep overrides a same-cycle wakeup.
        if (load_fired && (load_fired_index == IW'(i))) begin
          if (load_fired_sleep) begin
            ent_nxt[i].sleeping      = 1'b1;
            ent_nxt[i].executed      = 1'b0;
            ent_nxt[i].sleep_rob_tag = load_fired_sleep_rob_tag;
          end else begin
            ent_nxt[i].executed = 1'b1;
            ent_nxt[i].sleeping = 1'b0;
            if (load_fired_forward) begin
              ent_nxt[i].forwarded         = 1'b1;
              ent_nxt[i].forward_stq_index = load_fired_forward_index;
              ent_nxt[i].succeeded         = 1'b1;
            end
          end
        end
        if (load_succeeded && (load_succeeded_rob_tag == ent[i].rob_tag))
          ent_nxt[i].succeeded = 1'b1;
        if (rob_commit && (rob_commit_tag == ent[i].rob_tag))
          ent_nxt[i].committed = 1'b1;
        ent_nxt[i].order_fail = ent[i].order_fail | order_failures[i];
      end
      if (do_alloc) begin
        for (int k = 0; k < ALLOC_PORTS; k++) begin
          if (alloc_valid[k] && (alloc_index[k] == IW'(i))) begin
            ent_nxt[i]            = '0;
            ent_nxt[i].valid      = 1'b1;
            ent_nxt[i].rob_tag    = alloc_rob_tag[k];
            ent_nxt[i].store_mask = alloc_store_mask[k];
          end
        end
      end
      if (store_fired) ent_nxt[i].store_mask[store_fired_index] = 1'b0;
      if (flush && ent[i].valid && !ent[i].committed) ent_nxt[i] = '0;
      if (retire && (head == IW'(i))) ent_nxt[i] = '0;
    end
  end

  // Committed entries are contiguous from head, so the survivors end at head+n_commit.
  always_comb begin
    head_nxt = retire ? head + IW'(1) : head;
    if (flush) begin
      tail_nxt  = head + n_commit[IW-1:0];
      count_nxt = n_commit - CW'(retire);
    end else begin
      tail_nxt  = do_alloc ? tail + n_alloc[IW-1:0] : tail;
      count_nxt = count + (do_alloc ? n_alloc : '0) - CW'(retire);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ent   <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      ent   <= ent_nxt;
      head  <= head_nxt;
      tail  <= tail_nxt;
      count <= count_nxt;
    end
  end

  for (genvar i = 0; i < LDQ_SIZE; i++) begin : g_out
    assign ldq_valid[i]             = ent[i].valid;
    assign ldq_address[i]           = ent[i].address;
    assign ldq_address_valid[i]     = ent[i].address_valid;
    assign ldq_sleeping[i]          = ent[i].sleeping;
    assign ldq_sleep_rob_tag[i]     = ent[i].sleep_rob_tag;
    assign ldq_executed[i]          = ent[i].executed;
    assign ldq_succeeded[i]         = ent[i].succeeded;
    assign ldq_committed[i]         = ent[i].committed;
    assign ldq_order_fail[i]        = ent[i].order_fail;
    assign ldq_store_mask[i]        = ent[i].store_mask;
    assign ldq_forwarded[i]         = ent[i].forwarded;
    assign ldq_forward_stq_index[i] = ent[i].forward_stq_index;
    assign ldq_rob_tag[i]           = ent[i].rob_tag;
  end

  always_comb begin
    for (int j = 0; j < LDQ_SIZE; j++) begin
      ldq_rotated_valid[j]         = ent[head + IW'(j)].valid;
      ldq_rotated_address_valid[j] = ent[head + IW'(j)].address_valid;
      ldq_rotated_sleeping[j]      = ent[head + IW'(j)].sleeping;
      ldq_rotated_executed[j]      = ent[head + IW'(j)].executed;
    end
  end

endmodule

// File: tb/tb_multiport_load_queue.sv
// Directed bench for multiport_load_queue with a 4-entry queue and two lanes
// of allocation and AGU writeback.
module tb_multiport_load_queue;
  localparam int XL = 32;
  localparam int RT = 32;
  localparam int LS = 4;
  localparam int SS = 8;
  localparam int AP = 2;
  localparam int GP = 2;
  localparam int IW = 2;
  localparam int SW = 3;

  logic clk;
  logic reset;
  logic [AP-1:0]          alloc_valid;
  logic [AP-1:0][RT-1:0]  alloc_rob_tag;
  logic [AP-1:0][SS-1:0]  alloc_store_mask;
  logic                   alloc_ready;
  logic [AP-1:0][IW-1:0]  alloc_index;
  logic [GP-1:0]          agu_valid;
  logic [GP-1:0][XL-1:0]  agu_address;
  logic [GP-1:0][RT-1:0]  agu_rob_tag;
  logic                   cdb_active;
  logic [RT-1:0]          cdb_tag;
  logic                   load_fired;
  logic [IW-1:0]          load_fired_index;
  logic                   load_fired_sleep;
  logic [RT-1:0]          load_fired_sleep_rob_tag;
  logic                   load_fired_forward;
  logic [SW-1:0]          load_fired_forward_index;
  logic                   load_succeeded;
  logic [RT-1:0]          load_succeeded_rob_tag;
  logic                   rob_commit;
  logic [RT-1:0]          rob_commit_tag;
  logic [LS-1:0]          order_failures;
  logic                   store_fired;
  logic [SW-1:0]          store_fired_index;
  logic                   flush;
  logic [LS-1:0]          ldq_valid;
  logic [LS-1:0][XL-1:0]  ldq_address;
  logic [LS-1:0]          ldq_address_valid;
  logic [LS-1:0]          ldq_sleeping;
  logic [LS-1:0][RT-1:0]  ldq_sleep_rob_tag;
  logic [LS-1:0]          ldq_executed;
  logic [LS-1:0]          ldq_succeeded;
  logic [LS-1:0]          ldq_committed;
  logic [LS-1:0]          ldq_order_fail;
  logic [LS-1:0][SS-1:0]  ldq_store_mask;
  logic [LS-1:0]          ldq_forwarded;
  logic [LS-1:0][SW-1:0]  ldq_forward_stq_index;
  logic [LS-1:0][RT-1:0]  ldq_rob_tag;
  logic [LS-1:0]          ldq_rotated_valid;
  logic [LS-1:0]          ldq_rotated_address_valid;
  logic [LS-1:0]          ldq_rotated_sleeping;
  logic [LS-1:0]          ldq_rotated_executed;
  logic [IW-1:0]          head;
  logic [IW-1:0]          tail;
  logic [IW:0]            count;
  logic                   full;
  logic                   empty;

  int checks = 0;
  int errors = 0;

  multiport_load_queue #(
    .XLEN(XL), .ROB_TAG_WIDTH(RT), .LDQ_SIZE(LS), .STQ_SIZE(SS),
    .ALLOC_PORTS(AP), .AGU_PORTS(GP)
  ) dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_rob_tag(alloc_rob_tag),
    .alloc_store_mask(alloc_store_mask), .alloc_ready(alloc_ready),
    .alloc_index(alloc_index),
    .agu_valid(agu_valid), .agu_address(agu_address), .agu_rob_tag(agu_rob_tag),
    .cdb_active(cdb_active), .cdb_tag(cdb_tag),
    .load_fired(load_fired), .load_fired_index(load_fired_index),
    .load_fired_sleep(load_fired_sleep), .load_fired_sleep_rob_tag(load_fired_sleep_rob_tag),
    .load_fired_forward(load_fired_forward), .load_fired_forward_index(load_fired_forward_index),
    .load_succeeded(load_succeeded), .load_succeeded_rob_tag(load_succeeded_rob_tag),
    .rob_commit(rob_commit), .rob_commit_tag(rob_commit_tag),
    .order_failures(order_failures),
    .store_fired(store_fired), .store_fired_index(store_fired_index),
    .flush(flush),
    .ldq_valid(ldq_valid), .ldq_address(ldq_address), .ldq_address_valid(ldq_address_valid),
    .ldq_sleeping(ldq_sleeping), .ldq_sleep_rob_tag(ldq_sleep_rob_tag),
    .ldq_executed(ldq_executed), .ldq_succeeded(ldq_succeeded),
    .ldq_committed(ldq_committed), .ldq_order_fail(ldq_order_fail),
    .ldq_store_mask(ldq_store_mask), .ldq_forwarded(ldq_forwarded),
    .ldq_forward_stq_index(ldq_forward_stq_index), .ldq_rob_tag(ldq_rob_tag),
    .ldq_rotated_valid(ldq_rotated_valid), .ldq_rotated_address_valid(ldq_rotated_address_valid),
    .ldq_rotated_sleeping(ldq_rotated_sleeping), .ldq_rotated_executed(ldq_rotated_executed),
    .head(head), .tail(tail), .count(count), .full(full), .empty(empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle();
    alloc_valid = '0; alloc_rob_tag = '0; alloc_store_mask = '0;
    agu_valid = '0; agu_address = '0; agu_rob_tag = '0;
    cdb_active = 1'b0; cdb_tag = '0;
    load_fired = 1'b0; load_fired_index = '0; load_fired_sleep = 1'b0;
    load_fired_sleep_rob_tag = '0; load_fired_forward = 1'b0; load_fired_forward_index = '0;
    load_succeeded = 1'b0; load_succeeded_rob_tag = '0;
    rob_commit = 1'b0; rob_commit_tag = '0;
    order_failures = '0; store_fired = 1'b0; store_fired_index = '0; flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (head !== 2'd0) begin errors++; $display("FAIL reset_head: got %0d expected 0", head); end
    checks++; if (tail !== 2'd0) begin errors++; $display("FAIL reset_tail: got %0d expected 0", tail); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_empty_full: got %b/%b expected 1/0", empty, full); end
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_alloc_ready: got %b expected 1", alloc_ready); end
    checks++; if (ldq_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid: got %b expected 0000", ldq_valid); end
  endtask

  task automatic test_alloc();
    alloc_valid = 2'b11; alloc_rob_tag[0] = 5; alloc_rob_tag[1] = 6;
    alloc_store_mask[0] = 8'h0F; alloc_store_mask[1] = 8'h1F;
    #1;
    checks++; if (alloc_index[0] !== 2'd0 || alloc_index[1] !== 2'd1) begin errors++; $display("FAIL alloc_index_a: got %0d,%0d expected 0,1", alloc_index[0], alloc_index[1]); end
    step(); idle();
    checks++; if (ldq_valid !== 4'b0011) begin errors++; $display("FAIL alloc_valid_a: got %b expected 0011", ldq_valid); end
    checks++; if (tail !== 2'd2 || count !== 3'd2) begin errors++; $display("FAIL alloc_tail_count_a: got %0d,%0d expected 2,2", tail, count); end
    checks++; if (ldq_rob_tag[0] !== 32'd5 || ldq_rob_tag[1] !== 32'd6) begin errors++; $display("FAIL alloc_tags_a: got %0d,%0d expected 5,6", ldq_rob_tag[0], ldq_rob_tag[1]); end
    checks++; if (ldq_store_mask[1] !== 8'h1F) begin errors++; $display("FAIL alloc_mask_a: got %h expected 1f", ldq_store_mask[1]); end
    alloc_valid = 2'b11; alloc_rob_tag[0] = 7; alloc_rob_tag[1] = 8;
    alloc_store_mask[0] = 8'h3F; alloc_store_mask[1] = 8'h7F;
    #1;
    checks++; if (alloc_index[0] !== 2'd2 || alloc_index[1] !== 2'd3) begin errors++; $display("FAIL alloc_index_b: got %0d,%0d expected 2,3", alloc_index[0], alloc_index[1]); end
    step(); idle();
    checks++; if (full !== 1'b1 || alloc_ready !== 1'b0) begin errors++; $display("FAIL alloc_full: got full=%b ready=%b expected 1/0", full, alloc_ready); end
    checks++; if (count !== 3'd4 || tail !== 2'd0) begin errors++; $display("FAIL alloc_count_b: got %0d,%0d expected 4,0", count, tail); end
    alloc_valid = 2'b01; alloc_rob_tag[0] = 10;
    step(); idle();
    checks++; if (count !== 3'd4 || tail !== 2'd0 || ldq_rob_tag[0] !== 32'd5) begin errors++; $display("FAIL alloc_when_full: got count=%0d tail=%0d tag0=%0d expected 4,0,5", count, tail, ldq_rob_tag[0]); end
  endtask

  task automatic test_agu_sleep();
    agu_valid = 2'b11;
    agu_rob_tag[0] = 5; agu_address[0] = 32'h200;
    agu_rob_tag[1] = 5; agu_address[1] = 32'h100;
    step(); idle();
    checks++; if (ldq_address[0] !== 32'h100) begin errors++; $display("FAIL agu_address: got %h expected 100", ldq_address[0]); end
    checks++; if (ldq_address_valid !== 4'b0001) begin errors++; $display("FAIL agu_address_valid: got %b expected 0001", ldq_address_valid); end
    load_fired = 1'b1; load_fired_index = 2'd0; load_fired_sleep = 1'b1; load_fired_sleep_rob_tag = 9;
    step(); idle();
    checks++; if (ldq_sleeping !== 4'b0001 || ldq_executed[0] !== 1'b0) begin errors++; $display("FAIL fire_sleep: got sleeping=%b exec0=%b expected 0001/0", ldq_sleeping, ldq_executed[0]); end
    checks++; if (ldq_sleep_rob_tag[0] !== 32'd9) begin errors++; $display("FAIL sleep_tag: got %0d expected 9", ldq_sleep_rob_tag[0]); end
    checks++; if (ldq_rotated_sleeping !== 4'b0001) begin errors++; $display("FAIL rot_sleeping: got %b expected 0001", ldq_rotated_sleeping); end
    load_fired = 1'b1; load_fired_index = 2'd0; load_fired_sleep = 1'b1; load_fired_sleep_rob_tag = 9;
    cdb_active = 1'b1; cdb_tag = 9;
    step(); idle();
    checks++; if (ldq_sleeping[0] !== 1'b1) begin errors++; $display("FAIL sleep_beats_wake: got %b expected 1", ldq_sleeping[0]); end
    cdb_active = 1'b1; cdb_tag = 4;
    step(); idle();
    checks++; if (ldq_sleeping[0] !== 1'b1) begin errors++; $display("FAIL wake_wrong_tag: got %b expected 1", ldq_sleeping[0]); end
    cdb_active = 1'b1; cdb_tag = 9;
    step(); idle();
    checks++; if (ldq_sleeping[0] !== 1'b0) begin errors++; $display("FAIL wakeup: got %b expected 0", ldq_sleeping[0]); end
  endtask

  task automatic test_forward_misc();
    load_fired = 1'b1; load_fired_index = 2'd1; load_fired_forward = 1'b1; load_fired_forward_index = 3'd3;
    step(); idle();
    checks++; if (ldq_executed[1] !== 1'b1 || ldq_forwarded[1] !== 1'b1 || ldq_succeeded[1] !== 1'b1) begin errors++; $display("FAIL forward_flags: got exec=%b fwd=%b succ=%b expected 1/1/1", ldq_executed[1], ldq_forwarded[1], ldq_succeeded[1]); end
    checks++; if (ldq_forward_stq_index[1] !== 3'd3) begin errors++; $display("FAIL forward_index: got %0d expected 3", ldq_forward_stq_index[1]); end
    order_failures = 4'b1010; store_fired = 1'b1; store_fired_index = 3'd0;
    load_succeeded = 1'b1; load_succeeded_rob_tag = 7;
    step(); idle();
    checks++; if (ldq_order_fail !== 4'b1010) begin errors++; $display("FAIL order_fail: got %b expected 1010", ldq_order_fail); end
    checks++; if (ldq_store_mask[0] !== 8'h0E || ldq_store_mask[1] !== 8'h1E) begin errors++; $display("FAIL store_fired: got %h,%h expected 0e,1e", ldq_store_mask[0], ldq_store_mask[1]); end
    checks++; if (ldq_succeeded !== 4'b0110) begin errors++; $display("FAIL succeeded: got %b expected 0110", ldq_succeeded); end
    step();
    checks++; if (ldq_order_fail !== 4'b1010) begin errors++; $display("FAIL order_fail_sticky: got %b expected 1010", ldq_order_fail); end
  endtask

  task automatic test_retire();
    rob_commit = 1'b1; rob_commit_tag = 5;
    step(); idle();
    checks++; if (ldq_committed !== 4'b0001 || head !== 2'd0) begin errors++; $display("FAIL commit: got committed=%b head=%0d expected 0001,0", ldq_committed, head); end
    alloc_valid = 2'b01; alloc_rob_tag[0] = 12;
    #1;
    checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL ready_full_retire: got %b expected 0", alloc_ready); end
    step(); idle();
    checks++; if (head !== 2'd1 || count !== 3'd3 || tail !== 2'd0) begin errors++; $display("FAIL retire0: got head=%0d count=%0d tail=%0d expected 1,3,0", head, count, tail); end
    checks++; if (ldq_valid !== 4'b1110 || ldq_address[0] !== 32'd0 || ldq_rob_tag[0] !== 32'd0) begin errors++; $display("FAIL retire0_clear: got valid=%b addr=%h tag=%0d expected 1110,0,0", ldq_valid, ldq_address[0], ldq_rob_tag[0]); end
    rob_commit = 1'b1; rob_commit_tag = 6;
    step(); idle();
    step();
    checks++; if (head !== 2'd2 || count !== 3'd2 || ldq_valid !== 4'b1100 || alloc_ready !== 1'b1) begin errors++; $display("FAIL retire1: got head=%0d count=%0d valid=%b ready=%b expected 2,2,1100,1", head, count, ldq_valid, alloc_ready); end
    rob_commit = 1'b1; rob_commit_tag = 7;
    step(); idle();
    alloc_valid = 2'b10; alloc_rob_tag[1] = 11; alloc_store_mask[1] = 8'h05;
    #1;
    checks++; if (alloc_index[1] !== 2'd0) begin errors++; $display("FAIL alloc_index_lane1: got %0d expected 0", alloc_index[1]); end
    step(); idle();
    checks++; if (head !== 2'd3 || count !== 3'd2 || tail !== 2'd1) begin errors++; $display("FAIL alloc_with_retire: got head=%0d count=%0d tail=%0d expected 3,2,1", head, count, tail); end
    checks++; if (ldq_valid !== 4'b1001 || ldq_rob_tag[0] !== 32'd11 || ldq_store_mask[0] !== 8'h05) begin errors++; $display("FAIL alloc_with_retire_entry: got valid=%b tag=%0d mask=%h expected 1001,11,05", ldq_valid, ldq_rob_tag[0], ldq_store_mask[0]); end
    checks++; if (ldq_rotated_valid !== 4'b0011) begin errors++; $display("FAIL rot_valid: got %b expected 0011", ldq_rotated_valid); end
  endtask

  task automatic test_flush();
    reset = 1'b1; step(); reset = 1'b0;
    alloc_valid = 2'b11; alloc_rob_tag[0] = 1; alloc_rob_tag[1] = 2;
    step(); idle();
    rob_commit = 1'b1; rob_commit_tag = 1;
    step(); idle();
    step();
    alloc_valid = 2'b11; alloc_rob_tag[0] = 3; alloc_rob_tag[1] = 4;
    #1;
    checks++; if (alloc_index[0] !== 2'd2 || alloc_index[1] !== 2'd3) begin errors++; $display("FAIL flush_setup_index: got %0d,%0d expected 2,3", alloc_index[0], alloc_index[1]); end
    step(); idle();
    checks++; if (ldq_valid !== 4'b1110 || head !== 2'd1 || tail !== 2'd0 || count !== 3'd3) begin errors++; $display("FAIL flush_setup: got valid=%b head=%0d tail=%0d count=%0d expected 1110,1,0,3", ldq_valid, head, tail, count); end
    rob_commit = 1'b1; rob_commit_tag = 2;
    step(); idle();
    flush = 1'b1; alloc_valid = 2'b11; alloc_rob_tag[0] = 20; alloc_rob_tag[1] = 21;
    step(); idle();
    checks++; if (head !== 2'd2 || tail !== 2'd2 || count !== 3'd0) begin errors++; $display("FAIL flush_retire: got head=%0d tail=%0d count=%0d expected 2,2,0", head, tail, count); end
    checks++; if (ldq_valid !== 4'b0000 || empty !== 1'b1) begin errors++; $display("FAIL flush_clear: got valid=%b empty=%b expected 0000,1", ldq_valid, empty); end
    alloc_valid = 2'b01; alloc_rob_tag[0] = 20;
    step(); idle();
    alloc_valid = 2'b11; alloc_rob_tag[0] = 21; alloc_rob_tag[1] = 22;
    #1;
    checks++; if (alloc_index[0] !== 2'd3 || alloc_index[1] !== 2'd0) begin errors++; $display("FAIL wrap_index: got %0d,%0d expected 3,0", alloc_index[0], alloc_index[1]); end
    step(); idle();
    checks++; if (tail !== 2'd1 || count !== 3'd3 || ldq_valid !== 4'b1101) begin errors++; $display("FAIL wrap_alloc: got tail=%0d count=%0d valid=%b expected 1,3,1101", tail, count, ldq_valid); end
    checks++; if (ldq_rob_tag[3] !== 32'd21 || ldq_rob_tag[0] !== 32'd22) begin errors++; $display("FAIL wrap_tags: got %0d,%0d expected 21,22", ldq_rob_tag[3], ldq_rob_tag[0]); end
    flush = 1'b1;
    step(); idle();
    checks++; if (tail !== 2'd2 || head !== 2'd2 || count !== 3'd0 || ldq_valid !== 4'b0000) begin errors++; $display("FAIL flush_none_committed: got tail=%0d head=%0d count=%0d valid=%b expected 2,2,0,0000", tail, head, count, ldq_valid); end
  endtask

  task automatic test_reset_full();
    alloc_valid = 2'b11; alloc_rob_tag[0] = 30; alloc_rob_tag[1] = 31;
    step(); idle();
    alloc_valid = 2'b11; alloc_rob_tag[0] = 32; alloc_rob_tag[1] = 33;
    step(); idle();
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL refill_full: got %b expected 1", full); end
    reset = 1'b1; load_fired = 1'b1; load_fired_index = 2'd2;
    step(); idle(); reset = 1'b0;
    checks++; if (ldq_valid !== 4'b0000 || ldq_executed !== 4'b0000) begin errors++; $display("FAIL reset_full_entries: got valid=%b exec=%b expected 0000,0000", ldq_valid, ldq_executed); end
    checks++; if (head !== 2'd0 || tail !== 2'd0 || count !== 3'd0) begin errors++; $display("FAIL reset_full_ptrs: got head=%0d tail=%0d count=%0d expected 0,0,0", head, tail, count); end
    checks++; if (empty !== 1'b1 || full !== 1'b0 || alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_full_flags: got empty=%b full=%b ready=%b expected 1,0,1", empty, full, alloc_ready); end
    checks++; if (ldq_rob_tag[2] !== 32'd0) begin errors++; $display("FAIL reset_full_tag: got %0d expected 0", ldq_rob_tag[2]); end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_alloc();
    test_agu_sleep();
    test_forward_misc();
    test_retire();
    test_flush();
    test_reset_full();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
